// File: rtl/wb_arbiter.sv
// Merges pipeline W-stage writes with buffered MDU results onto the single register-file write port.
// The pipeline always wins; MDU results queue in a small FIFO and are squashed by younger writes.
module wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        P_Valid,
    input  logic [31:0] P_PC,
    input  logic [4:0]  P_A3,
    input  logic [31:0] P_DI,

    input  logic        M_Valid,
    output logic        M_Ready,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_A3,
    input  logic [31:0] M_DI,

    output logic        GRFWrite,
    output logic [31:0] PC,
    output logic [4:0]  A3,
    output logic [31:0] DI,
    output logic        Busy
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // FIFO storage; payload needs no reset because occupancy is tracked by count/live
    logic [31:0]     pc_mem_q [DEPTH];
    logic [4:0]      a3_mem_q [DEPTH];
    logic [31:0]     di_mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;

    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            grf_we_q, grf_we_d;
    logic [31:0]     pc_q, pc_d;
    logic [4:0]      a3_q, a3_d;
    logic [31:0]     di_q, di_d;

    logic            p_write;
    logic            push;
    logic            pop;
    logic            push_live;
    logic            head_live;

    assign p_write   = P_Valid && (P_A3 != 5'd0);
    assign M_Ready   = (count_q < CntW'(DEPTH));
    assign Busy      = (count_q != '0);
    assign push      = M_Valid && M_Ready;
    assign pop       = !p_write && (count_q != '0);
    // A same-cycle pipeline write to the same register is program-order later
    assign push_live = (M_A3 != 5'd0) && !(P_Valid && (P_A3 == M_A3));
    assign head_live = live_q[rptr_q];

    always_comb begin
        live_d = live_q;
        if (p_write) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a3_mem_q[i] == P_A3) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rptr_q] = 1'b0;
        end
        // Push slot never equals the pop slot: that needs count==0 or count==DEPTH
        if (push) begin
            live_d[wptr_q] = push_live;
        end
    end

    always_comb begin
        rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        grf_we_d = 1'b0;
        pc_d     = pc_q;
        a3_d     = a3_q;
        di_d     = di_q;
        if (p_write) begin
            grf_we_d = 1'b1;
            pc_d     = P_PC;
            a3_d     = P_A3;
            di_d     = P_DI;
        end else if (pop && head_live) begin
            grf_we_d = 1'b1;
            pc_d     = pc_mem_q[rptr_q];
            a3_d     = a3_mem_q[rptr_q];
            di_d     = di_mem_q[rptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            grf_we_q <= 1'b0;
            pc_q     <= '0;
            a3_q     <= '0;
            di_q     <= '0;
        end else begin
            live_q   <= live_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            grf_we_q <= grf_we_d;
            pc_q     <= pc_d;
            a3_q     <= a3_d;
            di_q     <= di_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wptr_q] <= M_PC;
            a3_mem_q[wptr_q] <= M_A3;
            di_mem_q[wptr_q] <= M_DI;
        end
    end

    assign GRFWrite = grf_we_q;
    assign PC       = pc_q;
    assign A3       = a3_q;
    assign DI       = di_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pass-through, priority, backpressure, kill and $0 handling.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        P_Valid;
    logic [31:0] P_PC;
    logic [4:0]  P_A3;
    logic [31:0] P_DI;
    logic        M_Valid;
    logic        M_Ready;
    logic [31:0] M_PC;
    logic [4:0]  M_A3;
    logic [31:0] M_DI;
    logic        GRFWrite;
    logic [31:0] PC;
    logic [4:0]  A3;
    logic [31:0] DI;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .P_Valid  (P_Valid),
        .P_PC     (P_PC),
        .P_A3     (P_A3),
        .P_DI     (P_DI),
        .M_Valid  (M_Valid),
        .M_Ready  (M_Ready),
        .M_PC     (M_PC),
        .M_A3     (M_A3),
        .M_DI     (M_DI),
        .GRFWrite (GRFWrite),
        .PC       (PC),
        .A3       (A3),
        .DI       (DI),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        P_Valid = 1'b1; P_PC = 32'h100; P_A3 = 5'd3; P_DI = 32'h33;
        M_Valid = 1'b1; M_PC = 32'h200; M_A3 = 5'd7; M_DI = 32'h77;
        #1;
        step();
        step();
        check("rst_grf",    32'(GRFWrite), 32'd0);
        check("rst_a3",     32'(A3),       32'd0);
        check("rst_di",     DI,            32'd0);
        check("rst_pc",     PC,            32'd0);
        check("rst_busy",   32'(Busy),     32'd0);
        check("rst_mready", 32'(M_Ready),  32'd1);
        reset = 1'b0; P_Valid = 1'b0; M_Valid = 1'b0;
        step();
        check("post_rst_busy", 32'(Busy),     32'd0);
        check("post_rst_grf",  32'(GRFWrite), 32'd0);

        // Pipeline pass-through
        P_Valid = 1'b1; P_A3 = 5'd5; P_DI = 32'h1234; P_PC = 32'h3000;
        step();
        check("pt_grf", 32'(GRFWrite), 32'd1);
        check("pt_a3",  32'(A3),       32'd5);
        check("pt_di",  DI,            32'h1234);
        check("pt_pc",  PC,            32'h3000);
        P_Valid = 1'b0;
        step();
        check("pt_grf_off", 32'(GRFWrite), 32'd0);
        check("pt_a3_hold", 32'(A3),       32'd5);

        // Priority and buffering
        M_Valid = 1'b1; M_A3 = 5'd8; M_DI = 32'hAA; M_PC = 32'h4000;
        step();
        M_Valid = 1'b0;
        check("pri_busy0", 32'(Busy),     32'd1);
        check("pri_grf0",  32'(GRFWrite), 32'd0);
        P_Valid = 1'b1; P_A3 = 5'd9; P_DI = 32'h99; P_PC = 32'h3004;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pri_p_grf",  32'(GRFWrite), 32'd1);
            check("pri_p_a3",   32'(A3),       32'd9);
            check("pri_p_busy", 32'(Busy),     32'd1);
        end
        P_Valid = 1'b0;
        step();
        check("pri_m_grf",  32'(GRFWrite), 32'd1);
        check("pri_m_a3",   32'(A3),       32'd8);
        check("pri_m_di",   DI,            32'hAA);
        check("pri_m_pc",   PC,            32'h4000);
        check("pri_m_busy", 32'(Busy),     32'd0);
        step();
        check("pri_idle", 32'(GRFWrite), 32'd0);

        // Backpressure
        P_Valid = 1'b1; P_A3 = 5'd1; P_DI = 32'h55; P_PC = 32'h3008;
        M_Valid = 1'b1; M_A3 = 5'd10; M_DI = 32'h101; M_PC = 32'h4100;
        check("bp_rdy0", 32'(M_Ready), 32'd1);
        step();
        M_A3 = 5'd11; M_DI = 32'h102; M_PC = 32'h4104;
        check("bp_rdy1", 32'(M_Ready), 32'd1);
        step();
        M_A3 = 5'd12; M_DI = 32'h103; M_PC = 32'h4108;
        check("bp_rdy2", 32'(M_Ready), 32'd0);
        check("bp_busy", 32'(Busy),    32'd1);
        step();
        step();
        check("bp_hold_rdy", 32'(M_Ready), 32'd0);
        check("bp_hold_a3",  32'(A3),      32'd1);
        P_Valid = 1'b0;
        step();
        check("bp_pop1_a3",  32'(A3),      32'd10);
        check("bp_pop1_di",  DI,           32'h101);
        check("bp_pop1_rdy", 32'(M_Ready), 32'd1);
        step();
        M_Valid = 1'b0;
        check("bp_pop2_a3",   32'(A3),       32'd11);
        check("bp_pop2_di",   DI,            32'h102);
        check("bp_pop2_busy", 32'(Busy),     32'd1);
        step();
        check("bp_pop3_grf",  32'(GRFWrite), 32'd1);
        check("bp_pop3_a3",   32'(A3),       32'd12);
        check("bp_pop3_di",   DI,            32'h103);
        check("bp_pop3_pc",   PC,            32'h4108);
        check("bp_pop3_busy", 32'(Busy),     32'd0);
        step();
        check("bp_idle", 32'(GRFWrite), 32'd0);

        // Kill by a later pipeline write
        M_Valid = 1'b1; M_A3 = 5'd4; M_DI = 32'h11; M_PC = 32'h4200;
        step();
        M_Valid = 1'b0;
        P_Valid = 1'b1; P_A3 = 5'd4; P_DI = 32'h22; P_PC = 32'h300C;
        step();
        P_Valid = 1'b0;
        check("kill_p_grf",  32'(GRFWrite), 32'd1);
        check("kill_p_di",   DI,            32'h22);
        check("kill_p_busy", 32'(Busy),     32'd1);
        step();
        check("kill_pop_grf",  32'(GRFWrite), 32'd0);
        check("kill_pop_di",   DI,            32'h22);
        check("kill_pop_busy", 32'(Busy),     32'd0);

        // Kill at push time: same-cycle pipeline write to the same register
        P_Valid = 1'b1; P_A3 = 5'd13; P_DI = 32'hBB; P_PC = 32'h3010;
        M_Valid = 1'b1; M_A3 = 5'd13; M_DI = 32'hCC; M_PC = 32'h4300;
        step();
        P_Valid = 1'b0; M_Valid = 1'b0;
        check("kpush_di",   DI,        32'hBB);
        check("kpush_busy", 32'(Busy), 32'd1);
        step();
        check("kpush_pop_grf", 32'(GRFWrite), 32'd0);
        check("kpush_pop_di",  DI,            32'hBB);

        // Register zero
        M_Valid = 1'b1; M_A3 = 5'd6; M_DI = 32'h66; M_PC = 32'h4400;
        step();
        M_Valid = 1'b0;
        P_Valid = 1'b1; P_A3 = 5'd0; P_DI = 32'hDEAD; P_PC = 32'h3014;
        step();
        P_Valid = 1'b0;
        check("z_pop_grf",  32'(GRFWrite), 32'd1);
        check("z_pop_a3",   32'(A3),       32'd6);
        check("z_pop_di",   DI,            32'h66);
        check("z_pop_busy", 32'(Busy),     32'd0);
        M_Valid = 1'b1; M_A3 = 5'd0; M_DI = 32'h77; M_PC = 32'h4404;
        check("z_m_rdy", 32'(M_Ready), 32'd1);
        step();
        M_Valid = 1'b0;
        check("z_m_busy", 32'(Busy),     32'd1);
        check("z_m_grf",  32'(GRFWrite), 32'd0);
        step();
        check("z_m_pop_grf",  32'(GRFWrite), 32'd0);
        check("z_m_pop_busy", 32'(Busy),     32'd0);
        check("z_m_pop_a3",   32'(A3),       32'd6);

        // Reset with an entry buffered
        M_Valid = 1'b1; M_A3 = 5'd14; M_DI = 32'hEE; M_PC = 32'h4500;
        step();
        M_Valid = 1'b0;
        check("mr_busy_pre", 32'(Busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_busy", 32'(Busy),     32'd0);
        check("mr_a3",   32'(A3),       32'd0);
        step();
        check("mr_grf",  32'(GRFWrite), 32'd0);
        check("mr_di",   DI,            32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
